// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU decode and the multiply/divide unit.
package alu_pkg;

    // aluop classes from the main decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_SLT   = 2'b11;

    // R-type funct codes
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;

    // main-ALU control encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;
    localparam logic [2:0] ALU_SLL = 3'b100;
    localparam logic [2:0] ALU_SRL = 3'b101;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2
    } md_state_t;

    // True for the eight funct codes owned by the mul/div unit (0110xx, 0100xx)
    function automatic logic is_md_funct(input logic [5:0] f);
        return (f[5:2] == 4'b0110) || (f[5:2] == 4'b0100);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply (shift-add) / divide (restoring), one bit per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   MD_IDLE | no operation; waiting for start
//   MD_MUL  | shift-add multiply; acc = running high half, mq = low half
//   MD_DIV  | restoring divide; acc = partial remainder, mq = quotient
//
// Signed operations run on magnitudes; the sign fixup is applied to the
// final-step values so hi_out/lo_out are ready on the cycle done is high.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op_div,
    input  logic             op_signed,
    input  logic             flush,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mq_q, mq_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             neg_q, neg_d;
    logic             neg_rem_q, neg_rem_d;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH-1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   acc_step, mq_step;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   mag_a, mag_b;

    // One iteration step plus sign fixup of its result
    always_comb begin
        mul_sum   = {1'b0, acc_q} + {1'b0, (mq_q[0] ? opnd_q : '0)};
        div_shift = {acc_q, mq_q[WIDTH-1]};
        // Only used when div_shift >= divisor, so the true difference fits WIDTH bits
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_ge    = (div_shift >= {1'b0, opnd_q});
        if (state_q == MD_MUL) begin
            acc_step = mul_sum[WIDTH:1];
            mq_step  = {mul_sum[0], mq_q[WIDTH-1:1]};
        end else begin
            acc_step = div_ge ? div_diff : div_shift[WIDTH-1:0];
            mq_step  = {mq_q[WIDTH-2:0], div_ge};
        end
        prod_fix = neg_q ? -{acc_step, mq_step} : {acc_step, mq_step};
        if (state_q == MD_MUL) begin
            hi_out = prod_fix[2*WIDTH-1:WIDTH];
            lo_out = prod_fix[WIDTH-1:0];
        end else begin
            hi_out = neg_rem_q ? -acc_step : acc_step;
            lo_out = neg_q ? -mq_step : mq_step;
        end
        busy = (state_q != MD_IDLE);
        done = busy && (cnt_q == CW'(1));
    end

    // Next-state: flush aborts, otherwise iterate or accept a new operation
    always_comb begin
        mag_a     = (op_signed && opa[WIDTH-1]) ? -opa : opa;
        mag_b     = (op_signed && opb[WIDTH-1]) ? -opb : opb;
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mq_d      = mq_q;
        opnd_d    = opnd_q;
        neg_d     = neg_q;
        neg_rem_d = neg_rem_q;
        if (flush) begin
            state_d = MD_IDLE;
            cnt_d   = '0;
        end else if (state_q != MD_IDLE) begin
            acc_d = acc_step;
            mq_d  = mq_step;
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                state_d = MD_IDLE;
            end
        end else if (start) begin
            state_d   = op_div ? MD_DIV : MD_MUL;
            cnt_d     = CW'(WIDTH);
            acc_d     = '0;
            mq_d      = mag_a;
            opnd_d    = mag_b;
            neg_d     = op_signed && (opa[WIDTH-1] ^ opb[WIDTH-1]);
            neg_rem_d = op_signed && opa[WIDTH-1];
        end
    end

    // Iteration registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mq_q      <= '0;
            opnd_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mq_q      <= mq_d;
            opnd_q    <= opnd_d;
            neg_q     <= neg_d;
            neg_rem_q <= neg_rem_d;
        end
    end

endmodule

// File: rtl/alu_muldiv_ctrl.sv
// EX-stage ALU control: alucontrol decode, HI/LO registers, mul/div
// sequencing and the stall handshake towards the pipeline controller.
module alu_muldiv_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid,
    input  logic             flush,
    input  logic [1:0]       aluop,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    output logic [2:0]       alucontrol,
    output logic             illegal,
    output logic             mdsel,
    output logic [WIDTH-1:0] mdresult,
    output logic             stall,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic             funct_legal;
    logic             md_class;
    logic             md_start;
    logic             mt_ok;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi, md_lo;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    // alucontrol / illegal decode; md codes map to ADD as a harmless default
    always_comb begin
        alucontrol  = ALU_ADD;
        funct_legal = 1'b1;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_SLT: alucontrol = ALU_SLT;
            default: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    F_SLL:   alucontrol = ALU_SLL;
                    F_SRL:   alucontrol = ALU_SRL;
                    default: begin
                        alucontrol  = ALU_ADD;
                        funct_legal = is_md_funct(funct);
                    end
                endcase
            end
        endcase
        illegal = valid && (aluop == ALUOP_RTYPE) && !funct_legal;
    end

    // Mul/div class qualification, stall handshake and MFHI/MFLO mux
    always_comb begin
        md_class = valid && (aluop == ALUOP_RTYPE) && is_md_funct(funct);
        stall    = md_busy && md_class && !flush;
        mt_ok    = md_class && !md_busy && !flush;
        md_start = mt_ok && (funct[5:2] == 4'b0110);
        mdsel    = md_class && ((funct == F_MFHI) || (funct == F_MFLO));
        mdresult = '0;
        if (mdsel) begin
            mdresult = funct[1] ? lo_q : hi_q;
        end
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (md_start),
        .op_div   (funct[1]),
        .op_signed(~funct[0]),
        .flush    (flush),
        .opa      (srca),
        .opb      (srcb),
        .busy     (md_busy),
        .done     (md_done),
        .hi_out   (md_hi),
        .lo_out   (md_lo)
    );

    // HI/LO next value: completion write, else MTHI/MTLO; flush blocks both
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (md_done && !flush) begin
            hi_d = md_hi;
            lo_d = md_lo;
        end else if (mt_ok && (funct == F_MTHI)) begin
            hi_d = srca;
        end else if (mt_ok && (funct == F_MTLO)) begin
            lo_d = srca;
        end
    end

    // Architectural HI/LO registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign busy = md_busy;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Bench for alu_muldiv_ctrl: runs the same tests on a 32-bit and an 8-bit instance.
module tb_alu_muldiv_ctrl;
    import alu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, valid, flush;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] srca, srcb;

    logic [2:0]  aluc32, aluc8;
    logic        ill32, ill8, mdsel32, mdsel8, stall32, stall8, busy32, busy8;
    logic [31:0] mdres32, hi32, lo32;
    logic [7:0]  mdres8, hi8, lo8;

    alu_muldiv_ctrl #(.WIDTH(32)) dut32 (
        .clk(clk), .reset_n(reset_n), .valid(valid), .flush(flush),
        .aluop(aluop), .funct(funct), .srca(srca), .srcb(srcb),
        .alucontrol(aluc32), .illegal(ill32), .mdsel(mdsel32), .mdresult(mdres32),
        .stall(stall32), .busy(busy32), .hi(hi32), .lo(lo32)
    );

    alu_muldiv_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .valid(valid), .flush(flush),
        .aluop(aluop), .funct(funct), .srca(srca[7:0]), .srcb(srcb[7:0]),
        .alucontrol(aluc8), .illegal(ill8), .mdsel(mdsel8), .mdresult(mdres8),
        .stall(stall8), .busy(busy8), .hi(hi8), .lo(lo8)
    );

    int          w = 32;
    logic        sel8;
    logic [31:0] mask;
    logic [2:0]  aluc_m;
    logic        ill_m, mdsel_m, stall_m, busy_m;
    logic [31:0] mdres_m, hi_m, lo_m;

    assign sel8    = (w == 8);
    assign mask    = sel8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    assign aluc_m  = sel8 ? aluc8 : aluc32;
    assign ill_m   = sel8 ? ill8 : ill32;
    assign mdsel_m = sel8 ? mdsel8 : mdsel32;
    assign stall_m = sel8 ? stall8 : stall32;
    assign busy_m  = sel8 ? busy8 : busy32;
    assign mdres_m = sel8 ? {24'd0, mdres8} : mdres32;
    assign hi_m    = sel8 ? {24'd0, hi8} : hi32;
    assign lo_m    = sel8 ? {24'd0, lo8} : lo32;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (w=%0d): got %h expected %h", name, w, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] a, input logic [31:0] b);
        valid = v; aluop = op; funct = f; srca = a; srcb = b;
    endtask

    task automatic idle();
        drive(1'b0, 2'b00, 6'd0, 32'd0, 32'd0);
        flush = 1'b0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Reference model: results straight from the arithmetic rules
    function automatic void md_model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                     input int wd, output logic [31:0] hi_e, output logic [31:0] lo_e);
        logic [63:0] m, ua, ub, p, hv, lv;
        longint      sa, sb, q, r, lim;
        m   = (64'd1 << wd) - 64'd1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        sa  = ua[wd-1] ? (longint'(ua) - longint'(64'd1 << wd)) : longint'(ua);
        sb  = ub[wd-1] ? (longint'(ub) - longint'(64'd1 << wd)) : longint'(ub);
        lim = -longint'(64'd1 << (wd - 1));
        hv  = 64'd0;
        lv  = 64'd0;
        case (f)
            F_MULTU: begin p = ua * ub; hv = (p >> wd) & m; lv = p & m; end
            F_MULT:  begin p = 64'(sa * sb); hv = (p >> wd) & m; lv = p & m; end
            F_DIVU: begin
                if (ub == 64'd0) begin lv = m; hv = ua; end
                else begin lv = ua / ub; hv = ua % ub; end
            end
            default: begin
                if (sb == 0) begin
                    lv = (sa >= 0) ? m : 64'd1;
                    hv = ua;
                end else if (sa == lim && sb == -1) begin
                    lv = 64'd1 << (wd - 1);
                    hv = 64'd0;
                end else begin
                    q = sa / sb; r = sa % sb;
                    lv = 64'(q) & m; hv = 64'(r) & m;
                end
            end
        endcase
        hi_e = hv[31:0];
        lo_e = lv[31:0];
    endfunction

    // Issue one mul/div, follow with MFHI/MFLO, count stall cycles, check results
    task automatic run_md(input string name, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input logic [5:0] follow);
        int n;
        drive(1'b1, ALUOP_RTYPE, f, a, b);
        next();
        drive(1'b1, ALUOP_RTYPE, follow, 32'd0, 32'd0);
        n = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (!stall_m) break;
            n++;
            next();
        end
        check({name, " stall cycles"}, n, w);
        check({name, " busy"}, busy_m, 0);
        check({name, " hi"}, hi_m, exp_hi);
        check({name, " lo"}, lo_m, exp_lo);
        check({name, " mdresult"}, mdres_m, (follow == F_MFHI) ? exp_hi : exp_lo);
        next();
        idle();
    endtask

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [5:0] f;
        logic [2:0] ac;
        logic       ill;
        logic       msel;
    } dec_vec_t;

    typedef struct {
        string       name;
        logic [5:0]  f;
        logic [31:0] a32, b32, hi32, lo32;
        logic [31:0] a8, b8, hi8, lo8;
    } md_vec_t;

    dec_vec_t dtab[16];
    md_vec_t  mtab[8];

    function automatic logic [31:0] rand_opnd();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            3:       return 32'd1;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] mh, ml, ra, rb, eh, el;
        logic [5:0]  rf;
        logic [1:0]  rop;
        logic [2:0]  rac;
        int          kind, fc;

        dtab[0]  = '{1'b1, 2'b00, 6'b111111, 3'b010, 1'b0, 1'b0};
        dtab[1]  = '{1'b1, 2'b01, 6'b100000, 3'b110, 1'b0, 1'b0};
        dtab[2]  = '{1'b1, 2'b11, 6'b000000, 3'b111, 1'b0, 1'b0};
        dtab[3]  = '{1'b1, 2'b10, 6'b100000, 3'b010, 1'b0, 1'b0};
        dtab[4]  = '{1'b1, 2'b10, 6'b100010, 3'b110, 1'b0, 1'b0};
        dtab[5]  = '{1'b1, 2'b10, 6'b100100, 3'b000, 1'b0, 1'b0};
        dtab[6]  = '{1'b1, 2'b10, 6'b100101, 3'b001, 1'b0, 1'b0};
        dtab[7]  = '{1'b1, 2'b10, 6'b101010, 3'b111, 1'b0, 1'b0};
        dtab[8]  = '{1'b1, 2'b10, 6'b000000, 3'b100, 1'b0, 1'b0};
        dtab[9]  = '{1'b1, 2'b10, 6'b000010, 3'b101, 1'b0, 1'b0};
        dtab[10] = '{1'b1, 2'b10, 6'b011000, 3'b010, 1'b0, 1'b0};
        dtab[11] = '{1'b1, 2'b10, 6'b010000, 3'b010, 1'b0, 1'b1};
        dtab[12] = '{1'b1, 2'b10, 6'b010010, 3'b010, 1'b0, 1'b1};
        dtab[13] = '{1'b1, 2'b10, 6'b111111, 3'b010, 1'b1, 1'b0};
        dtab[14] = '{1'b0, 2'b10, 6'b111111, 3'b010, 1'b0, 1'b0};
        dtab[15] = '{1'b1, 2'b10, 6'b000001, 3'b010, 1'b1, 1'b0};

        mtab[0] = '{"multu max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001,
                    32'hFF, 32'hFF, 32'hFE, 32'h01};
        mtab[1] = '{"mult -3x5", F_MULT, 32'hFFFFFFFD, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFF1,
                    32'hFD, 32'h05, 32'hFF, 32'hF1};
        mtab[2] = '{"div -7/2", F_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD,
                    32'hF9, 32'h02, 32'hFF, 32'hFD};
        mtab[3] = '{"div ovf", F_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000,
                    32'h80, 32'hFF, 32'h00, 32'h80};
        mtab[4] = '{"divu 5/0", F_DIVU, 32'h5, 32'h0, 32'h5, 32'hFFFFFFFF,
                    32'h05, 32'h00, 32'h05, 32'hFF};
        mtab[5] = '{"div -9/0", F_DIV, 32'hFFFFFFF7, 32'h0, 32'hFFFFFFF7, 32'h00000001,
                    32'hF7, 32'h00, 32'hF7, 32'h01};
        mtab[6] = '{"div 7/-2", F_DIV, 32'h7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD,
                    32'h07, 32'hFE, 32'h01, 32'hFD};
        mtab[7] = '{"multu x16", F_MULTU, 32'h12345678, 32'h10, 32'h1, 32'h23456780,
                    32'h78, 32'h10, 32'h07, 32'h80};

        reset_n = 1'b0;
        idle();

        for (int pass = 0; pass < 2; pass++) begin
            w = (pass == 0) ? 32 : 8;

            // Reset state
            reset_n = 1'b0;
            next(); next();
            reset_n = 1'b1;
            @(negedge clk);
            check("reset busy", busy_m, 0);
            check("reset hi", hi_m, 0);
            check("reset lo", lo_m, 0);
            next();

            // Reset in the middle of a DIV
            drive(1'b1, ALUOP_RTYPE, F_MTHI, 32'h5, 32'h0); next();
            drive(1'b1, ALUOP_RTYPE, F_MTLO, 32'h6, 32'h0); next();
            drive(1'b1, ALUOP_RTYPE, F_DIV, 32'h64, 32'h3); next();
            idle(); next(); next();
            reset_n = 1'b0; next(); next();
            reset_n = 1'b1;
            drive(1'b1, ALUOP_RTYPE, F_MFHI, 32'h0, 32'h0);
            @(negedge clk);
            check("midreset busy", busy_m, 0);
            check("midreset stall", stall_m, 0);
            check("midreset hi", hi_m, 0);
            check("midreset lo", lo_m, 0);
            check("midreset mdresult", mdres_m, 0);
            next(); idle();

            // Decode table (flush keeps md codes from starting anything)
            flush = 1'b1;
            foreach (dtab[i]) begin
                drive(dtab[i].v, dtab[i].op, dtab[i].f, 32'd0, 32'd0);
                @(negedge clk);
                check($sformatf("decode[%0d] alucontrol", i), aluc_m, dtab[i].ac);
                check($sformatf("decode[%0d] illegal", i), ill_m, dtab[i].ill);
                check($sformatf("decode[%0d] mdsel", i), mdsel_m, dtab[i].msel);
                next();
            end
            idle();

            // Mul/div corner cases
            foreach (mtab[i]) begin
                if (sel8) run_md(mtab[i].name, mtab[i].f, mtab[i].a8, mtab[i].b8,
                                 mtab[i].hi8, mtab[i].lo8, (i % 2 == 0) ? F_MFHI : F_MFLO);
                else      run_md(mtab[i].name, mtab[i].f, mtab[i].a32, mtab[i].b32,
                                 mtab[i].hi32, mtab[i].lo32, (i % 2 == 0) ? F_MFHI : F_MFLO);
            end

            // Flush mid-operation; non-md ADD while busy must not stall
            fc = sel8 ? 5 : 10;
            drive(1'b1, ALUOP_RTYPE, F_MTHI, 32'h1, 32'h0); next();
            drive(1'b1, ALUOP_RTYPE, F_MTLO, 32'h2, 32'h0); next();
            drive(1'b1, ALUOP_RTYPE, F_MULT, 32'h3, 32'h4); next();
            for (int c = 1; c < fc; c++) begin
                if (c == 3) drive(1'b1, ALUOP_RTYPE, F_ADD, 32'h0, 32'h0);
                else        idle();
                @(negedge clk);
                if (c == 3) begin
                    check("add while busy stall", stall_m, 0);
                    check("add while busy busy", busy_m, 1);
                    check("add while busy alucontrol", aluc_m, ALU_ADD);
                end
                next();
            end
            idle();
            flush = 1'b1;
            next();
            flush = 1'b0;
            @(negedge clk);
            check("flush busy", busy_m, 0);
            check("flush hi kept", hi_m, 32'h1);
            check("flush lo kept", lo_m, 32'h2);
            next();

            // Flush on the completion cycle suppresses the write
            drive(1'b1, ALUOP_RTYPE, F_MULTU, 32'h3, 32'h4); next();
            idle();
            for (int c = 1; c < w; c++) next();
            flush = 1'b1;
            @(negedge clk);
            check("flush@done busy", busy_m, 1);
            next();
            flush = 1'b0;
            @(negedge clk);
            check("flush@done busy after", busy_m, 0);
            check("flush@done hi", hi_m, 32'h1);
            check("flush@done lo", lo_m, 32'h2);
            next();

            // MTLO in IDLE: no same-cycle bypass, visible next cycle
            drive(1'b1, ALUOP_RTYPE, F_MTLO, 32'h1234, 32'h0);
            @(negedge clk);
            check("mtlo same cycle", lo_m, 32'h2);
            next(); idle();
            @(negedge clk);
            check("mtlo next cycle", lo_m, 32'h1234 & mask);
            next();

            // MTHI arriving while busy is held and executes after completion
            drive(1'b1, ALUOP_RTYPE, F_DIVU, 32'd100, 32'd7); next();
            drive(1'b1, ALUOP_RTYPE, F_MTHI, 32'hAB, 32'h0);
            fc = 0;
            for (int c = 0; c < 80; c++) begin
                @(negedge clk);
                if (!stall_m) break;
                fc++;
                next();
            end
            check("held mthi stall cycles", fc, w);
            next(); idle();
            @(negedge clk);
            check("held mthi hi", hi_m, 32'hAB);
            check("held mthi lo", lo_m, 32'd14);
            next();

            // Random stream against the model
            mh = hi_m; ml = lo_m;
            for (int i = 0; i < 40; i++) begin
                kind = $urandom_range(0, 9);
                ra = rand_opnd();
                rb = rand_opnd();
                rop = ALUOP_RTYPE;
                rac = ALU_ADD;
                case (kind)
                    0, 1, 2, 3: rf = {4'b0110, 2'(kind)};
                    4:          rf = F_MTHI;
                    5:          rf = F_MTLO;
                    6:          rf = F_MFHI;
                    7:          rf = F_MFLO;
                    default: begin
                        rf = 6'b000000;
                        case ($urandom_range(0, 2))
                            0:       begin rop = ALUOP_ADD; rac = ALU_ADD; end
                            1:       begin rop = ALUOP_SUB; rac = ALU_SUB; end
                            default: begin rop = ALUOP_SLT; rac = ALU_SLT; end
                        endcase
                    end
                endcase
                drive(1'b1, rop, rf, ra, rb);
                for (int c = 0; c < 80; c++) begin
                    @(negedge clk);
                    if (!stall_m) break;
                    next();
                end
                check("rand accepted", stall_m, 0);
                if (kind >= 8) check("rand alucontrol", aluc_m, rac);
                if (kind == 6) check("rand mfhi", mdres_m, mh);
                if (kind == 7) check("rand mflo", mdres_m, ml);
                if (kind <= 3) begin
                    md_model(rf, ra, rb, w, eh, el);
                    mh = eh; ml = el;
                end
                if (kind == 4) mh = ra & mask;
                if (kind == 5) ml = ra & mask;
                next();
            end
            idle();
            for (int c = 0; c < w + 2; c++) next();
            @(negedge clk);
            check("rand final hi", hi_m, mh);
            check("rand final lo", lo_m, ml);
            next();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_ctrl.md
Name: alu_muldiv_ctrl

Overview:
Next-generation ALU control for the MIPS core, parametrised in datapath width. It keeps the combinational aluop/funct to alucontrol decode and adds a multi-cycle multiply/divide unit with architectural HI/LO registers. It also handles the MFHI/MFLO/MTHI/MTLO moves and generates a pipeline stall handshake. It sits in the EX stage beside the main ALU; the controller feeds it stage-held operands and instruction fields.

Parameters:
WIDTH, 32, datapath/operand width in bits; legal range 4..64. HI and LO are each WIDTH bits.

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous, active-low reset
valid  in  1  EX-stage instruction is valid (not a bubble)
flush  in  1  abort any in-flight mul/div; ignore this cycle's instruction
aluop  in  2  ALU op class from main decoder
funct  in  6  R-type function field
srca  in  WIDTH  operand A (rs)
srcb  in  WIDTH  operand B (rt)
alucontrol  out  3  main-ALU control
illegal  out  1  aluop=10 with an undefined funct
mdsel  out  1  EX result comes from mdresult (MFHI/MFLO)
mdresult  out  WIDTH  HI for MFHI, LO for MFLO, else 0
stall  out  1  hold EX and earlier stages this cycle
busy  out  1  iterative mul/div in progress
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (reset_n=0 at an edge): state=IDLE, counter=0, hi=lo=0, busy=0. Reset aborts any operation in progress. Combinational outputs follow their inputs.
- Decode, combinational:
  - aluop 00 gives 010; 01 gives 110; 11 gives 111.
  - aluop 10 uses funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, 000000→100, 000010→101.
  - funct 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010000 MFHI, 010001 MTHI, 010010 MFLO, 010011 MTLO are legal. They give alucontrol=010 (don't-care for the ALU).
  - Any other funct under aluop 10: alucontrol=010, illegal=valid. No X is ever driven.
- "md-class" means any of the eight funct codes above with aluop=10 and valid=1.
- stall = busy & md-class & ~flush. Non-md instructions never stall.
- Start: in IDLE, a md-class MULT/MULTU/DIV/DIVU with stall=0 and flush=0 is accepted at the edge.
  - Operands are captured. Signed ops capture magnitudes plus result-sign flags.
  - State moves to MUL or DIV; counter=WIDTH.
- Iteration: MUL is shift-add and DIV is restoring, one bit per cycle. busy=1 in every cycle while state≠IDLE, i.e. cycles 1..WIDTH after the start edge.
- Completion: on the edge ending cycle WIDTH, hi/lo are written (sign fixup applied) and state returns to IDLE. Results are visible and busy=0 from cycle WIDTH+1.
- MUL writes the 2·WIDTH-bit product: {hi,lo}. Signed mode uses two's-complement result.
- DIV writes lo=quotient, hi=remainder. Signed mode: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide-by-zero has no trap and gives deterministic results:
  - DIVU: lo=all-ones, hi=dividend.
  - DIV: lo = all-ones if dividend ≥0, else 1; hi=dividend.
- Signed overflow, most-negative / -1: lo=most-negative, hi=0.
- MTHI/MTLO in IDLE (stall=0): hi or lo ← srca at the edge. MFHI/MFLO: mdsel=1, mdresult = current hi/lo register. There is no same-cycle bypass of a write.
- A md-class instruction arriving while busy stalls with the same inputs held until busy drops, then executes normally.
- flush=1: state→IDLE at the edge and the in-flight result is discarded. hi/lo are unchanged, and any start or MT* this cycle is ignored. flush on the completion cycle suppresses the hi/lo write.
- Priority: reset_n > flush > completion > start/MT*.

Decomposition:
- Package alu_pkg:
  - funct codes as localparams.
  - alucontrol encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL).
  - aluop encodings.
  - enum md_state_t {MD_IDLE, MD_MUL, MD_DIV}.
- Sub-module muldiv_iter #(WIDTH): iteration registers, counter and sign fixup, with start/op/flush inputs and done/hi_out/lo_out outputs.
- Decode, stall and HI/LO registers stay in the top level.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles during a DIV → busy=0, hi=lo=0, stall=0 on the next cycle.
- Decode: aluop=10/funct=100101 → alucontrol=001, illegal=0. funct=111111 → alucontrol=010, illegal=1. aluop=11 → 111.
- MULTU 0xFFFFFFFF×0xFFFFFFFF (WIDTH=32), then MFHI next cycle:
  - stall=1 for cycles 1..32.
  - Cycle 33: hi=0xFFFFFFFE, lo=0x00000001, mdresult=0xFFFFFFFE.
  - MULT -3×5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- Divide cases:
  - DIV -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - DIV 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
  - DIVU 5/0 → lo=0xFFFFFFFF, hi=5.
- Flush: MTHI 1 then MTLO 2, start MULT, assert flush in cycle 10 → busy=0 from cycle 11; hi=1, lo=2 retained.
- Non-md ADD while busy → stall=0. MTLO 0x1234 in IDLE → lo=0x1234 next cycle. Repeat all cases with WIDTH=8 (8-cycle latency).
